hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core; the stall and flush side of the bypass network, next to the `Forwarding` unit. It detects load-use hazards, taken-branch flushes and data-memory wait states. It drives the PC and pipeline-register write enables and flushes. A small FSM tracks outstanding data-memory accesses with a timeout, and optional counters record stall and flush activity.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: max consecutive wait cycles before the timeout error.
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`  in  1  core clock. Everything is on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ID_EX_MemRead`  in  1  the instruction in EX is a load.
- `ID_EX_RegisterRt`  in  5  load destination in EX.
- `IF_ID_RegisterRs`, `IF_ID_RegisterRt`  in  5 each  source registers of the instruction in ID.
- `IF_ID_UsesRt`  in  1  the ID instruction reads rt (R-type, store, branch).
- `EX_MEM_MemRead`, `EX_MEM_MemWrite`  in  1 each  a memory access is in MEM.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `branch_taken`  in  1  branch or jump resolved taken in EX.
- `PCWrite`, `IF_ID_Write`, `ID_EX_Write`, `EX_MEM_Write`  out  1 each  register update enables.
- `IF_ID_Flush`, `ID_EX_Flush`, `MEM_WB_Flush`  out  1 each  insert a bubble, which zeroes the control bits.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cycles`, `flush_events`  out  CNT_W each  performance counters.

## Operation
- FSM states: RUN, MEM_WAIT. Reset state: RUN.
- **RUN**, memory pending: `EX_MEM_MemRead|EX_MEM_MemWrite` with `dmem_ready=0`.
  - Go to MEM_WAIT.
  - Freeze combinationally in the same cycle: all `*_Write`=0, `MEM_WB_Flush`=1, other flushes 0.
- **MEM_WAIT**:
  - Hold the freeze while `dmem_ready=0`. The wait counter increments each cycle.
  - On `dmem_ready=1`, release in that same cycle (RUN outputs) and return to RUN.
  - When the wait counter reaches `MEM_TIMEOUT`:
    - set `mem_timeout`; it stays set until reset;
    - force release and return to RUN;
    - the access is dropped and WB receives a bubble.
- **Taken branch** (RUN, no memory wait), `branch_taken=1`:
  - `IF_ID_Flush=1` and `ID_EX_Flush=1`.
  - `PCWrite=1` so the PC loads the target. All other enables are 1.
- **Load-use** (RUN, no wait, no taken branch):
  - Condition: `ID_EX_MemRead`, `ID_EX_RegisterRt!=0`, and Rt equals `IF_ID_RegisterRs`, or equals `IF_ID_RegisterRt` when `IF_ID_UsesRt`.
  - Action: `PCWrite=0`, `IF_ID_Write=0`, `ID_EX_Flush=1`. The rest are enabled.
  - Exactly one bubble. The following cycle ID_EX holds the bubble (MemRead=0), so the condition does not re-fire.
- **Priority**: memory wait > taken branch > load-use. A branch or load-use seen during a freeze is re-evaluated on release, because the inputs are held by the frozen registers.
- **Idle**: all `*_Write`=1, all flushes 0.

## Timing
- Control outputs are combinational from state and inputs: zero latency.
- The state, wait counter, `mem_timeout` and counters are registered.
- While `rst_n`=0, regardless of state or inputs:
  - all `*_Write`=0 and all flushes=1;
  - `mem_timeout`=0, counters=0, state RUN.
- A reset asserted in MEM_WAIT aborts the wait immediately. The wait counter clears.
- Wait counter: cleared on entry to RUN, width `$clog2(MEM_TIMEOUT+1)`.
- A memory op with `dmem_ready=1` on its first MEM cycle causes no stall and no state change.

## Configuration
- Macro: `HAZARD_PERF_CNT_EN`.
- Defined:
  - `stall_cycles` +1 every cycle with `PCWrite=0` while out of reset. Both load-use and memory-wait stalls count.
  - `flush_events` +1 every cycle with `branch_taken` acted on.
  - Both counters saturate at all-ones.
- Undefined:
  - No counter flops.
  - Both outputs are tied to 0.

## Structure
- Shared package `hazard_pkg` holds:
  - the FSM state enum `hazard_state_t` {RUN, MEM_WAIT};
  - the default `MEM_TIMEOUT`.
- One sub-module, `hazard_perf_cnt`: a saturating counter with `clk`, `rst_n`, `inc` and `count` ports. It is instantiated twice under the macro.

## Test plan
- Load-use: `lw $2` in EX, `add $3,$2,$4` in ID -> one cycle of `PCWrite=0`, `IF_ID_Write=0`, `ID_EX_Flush=1`, then all enables 1. `stall_cycles`=1.
- Load to `$0`, or no rt match with `IF_ID_UsesRt=0` -> no stall.
- Memory wait: `EX_MEM_MemRead=1`, `dmem_ready` low 3 cycles, then high -> freeze for 3 cycles with `MEM_WB_Flush=1`, released in cycle 4. `stall_cycles`=3.
- Wait plus branch: `branch_taken=1` during a 2-cycle wait -> no flush during the freeze; on release `IF_ID_Flush=ID_EX_Flush=1`. `flush_events`=1.
- Timeout, with `MEM_TIMEOUT=4` and `dmem_ready` held 0 -> `mem_timeout` rises after 4 wait cycles, FSM returns to RUN, and the flag stays 1 through later traffic.
- Reset: `rst_n` low mid MEM_WAIT -> all enables 0 and flushes 1 immediately; after release, state RUN and counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding and default configuration values.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_t;

  // Longest data-memory wait tolerated before the access is abandoned.
  localparam int HAZARD_MEM_TIMEOUT = 255;

  // Default width of the performance counters.
  localparam int HAZARD_CNT_W = 32;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for stall / flush statistics.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count qualifying cycles, sticking at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall / flush controller for the 5-stage MIPS pipeline.
// Handles data-memory wait states (with timeout), taken-branch flushes and
// load-use bubbles. Optional performance counters are enabled by defining
// HAZARD_PERF_CNT_EN; without it stall_cycles and flush_events read 0.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = HAZARD_MEM_TIMEOUT,
  parameter int CNT_W       = HAZARD_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRt,
  input  logic [4:0]       IF_ID_RegisterRs,
  input  logic [4:0]       IF_ID_RegisterRt,
  input  logic             IF_ID_UsesRt,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MEM_WB_Flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hazard_state_t     state;
  hazard_state_t     stateNext;
  logic [WAIT_W-1:0] waitCnt;

  logic memPending;
  logic loadUse;
  logic timeoutHit;
  logic freeze;
  logic branchAct;

  // Hazard conditions. The wait counter includes the first frozen cycle spent
  // in RUN, so a timeout releases after exactly MEM_TIMEOUT frozen cycles.
  assign memPending = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign loadUse    = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                      ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                       (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));
  assign timeoutHit = (state == MEM_WAIT) && !dmem_ready &&
                      (waitCnt == WAIT_W'(MEM_TIMEOUT));
  assign freeze     = ((state == RUN) && memPending && !dmem_ready) ||
                      ((state == MEM_WAIT) && !dmem_ready && !timeoutHit);
  assign branchAct  = rst_n && !freeze && branch_taken;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and pipeline enables/flushes; memory wait outranks branch,
  // branch outranks load-use, and reset forces every stage into a bubble.
  always_comb begin
    stateNext    = state;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MEM_WB_Flush = 1'b0;

    case (state)
      RUN:      if (memPending && !dmem_ready) stateNext = MEM_WAIT;
      MEM_WAIT: if (dmem_ready || timeoutHit)  stateNext = RUN;
      default:  stateNext = RUN;
    endcase

    if (!rst_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else if (freeze) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else begin
      if (branchAct) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else if (loadUse) begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
      // An abandoned access must not reach write-back.
      if (timeoutHit) MEM_WB_Flush = 1'b1;
    end
  end

  // Wait counter: zero whenever the FSM is (or is about to be) in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (stateNext == RUN) begin
      waitCnt <= '0;
    end else begin
      waitCnt <= waitCnt + WAIT_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_timeout <= 1'b0;
    end else if (timeoutHit) begin
      mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stallInc;

  assign stallInc = ~PCWrite;

  hazard_perf_cnt #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stallInc),
    .count (stall_cycles)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branchAct),
    .count (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit, built with MEM_TIMEOUT=4.
module tb_hazard_unit;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector: {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
  //                  IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush}
  localparam logic [6:0] C_IDLE   = 7'b1111_000;
  localparam logic [6:0] C_FREEZE = 7'b0000_001;
  localparam logic [6:0] C_RST    = 7'b0000_111;
  localparam logic [6:0] C_BR     = 7'b1111_110;
  localparam logic [6:0] C_LU     = 7'b0011_010;
  localparam logic [6:0] C_TOREL  = 7'b1111_001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_RegisterRt;
  logic [4:0]  IF_ID_RegisterRs;
  logic [4:0]  IF_ID_RegisterRt;
  logic        IF_ID_UsesRt;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic        dmem_ready;
  logic        branch_taken;
  logic        PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic        IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
  logic [6:0]  ctl;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_RegisterRt (ID_EX_RegisterRt),
    .IF_ID_RegisterRs (IF_ID_RegisterRs),
    .IF_ID_RegisterRt (IF_ID_RegisterRt),
    .IF_ID_UsesRt     (IF_ID_UsesRt),
    .EX_MEM_MemRead   (EX_MEM_MemRead),
    .EX_MEM_MemWrite  (EX_MEM_MemWrite),
    .dmem_ready       (dmem_ready),
    .branch_taken     (branch_taken),
    .PCWrite          (PCWrite),
    .IF_ID_Write      (IF_ID_Write),
    .ID_EX_Write      (ID_EX_Write),
    .EX_MEM_Write     (EX_MEM_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Flush      (ID_EX_Flush),
    .MEM_WB_Flush     (MEM_WB_Flush),
    .mem_timeout      (mem_timeout),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );

  assign ctl = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clearIn();
    ID_EX_MemRead    = 1'b0;
    ID_EX_RegisterRt = 5'd0;
    IF_ID_RegisterRs = 5'd0;
    IF_ID_RegisterRt = 5'd0;
    IF_ID_UsesRt     = 1'b0;
    EX_MEM_MemRead   = 1'b0;
    EX_MEM_MemWrite  = 1'b0;
    dmem_ready       = 1'b0;
    branch_taken     = 1'b0;
  endtask

  task automatic setLoadUse();
    ID_EX_MemRead    = 1'b1;
    ID_EX_RegisterRt = 5'd2;
    IF_ID_RegisterRs = 5'd2;
    IF_ID_RegisterRt = 5'd4;
    IF_ID_UsesRt     = 1'b1;
  endtask

  initial begin
    clearIn();
    rst_n = 1'b0;
    EX_MEM_MemRead = 1'b1;

    // Reset: bubbles everywhere regardless of pending inputs
    nextCycle();
    #1;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_flush", flush_events, 32'd0);

    nextCycle();
    rst_n = 1'b1;
    clearIn();
    #1;
    chk("idle_ctl", 32'(ctl), 32'(C_IDLE));

    // Load-use: lw $2 in EX, add $3,$2,$4 in ID
    nextCycle();
    setLoadUse();
    #1;
    chk("lu_ctl", 32'(ctl), 32'(C_LU));
    nextCycle();
    ID_EX_MemRead = 1'b0;
    #1;
    chk("lu_after_ctl", 32'(ctl), 32'(C_IDLE));
    chk("lu_stall", stall_cycles, cnt(1));

    // Match on rt only counts when the ID instruction reads rt
    ID_EX_MemRead = 1'b1;
    ID_EX_RegisterRt = 5'd5;
    IF_ID_RegisterRs = 5'd1;
    IF_ID_RegisterRt = 5'd5;
    IF_ID_UsesRt = 1'b1;
    #1;
    chk("lu_rt_ctl", 32'(ctl), 32'(C_LU));
    IF_ID_UsesRt = 1'b0;
    #1;
    chk("lu_rt_unused_ctl", 32'(ctl), 32'(C_IDLE));
    ID_EX_RegisterRt = 5'd0;
    IF_ID_RegisterRs = 5'd0;
    IF_ID_RegisterRt = 5'd0;
    IF_ID_UsesRt = 1'b1;
    #1;
    chk("lu_r0_ctl", 32'(ctl), 32'(C_IDLE));

    // Memory wait: three cycles of dmem_ready=0, released on the fourth
    nextCycle();
    clearIn();
    EX_MEM_MemRead = 1'b1;
    #1;
    chk("mw_c1_ctl", 32'(ctl), 32'(C_FREEZE));
    nextCycle();
    #1;
    chk("mw_c2_ctl", 32'(ctl), 32'(C_FREEZE));
    nextCycle();
    #1;
    chk("mw_c3_ctl", 32'(ctl), 32'(C_FREEZE));
    nextCycle();
    dmem_ready = 1'b1;
    #1;
    chk("mw_rel_ctl", 32'(ctl), 32'(C_IDLE));
    nextCycle();
    clearIn();
    #1;
    chk("mw_after_ctl", 32'(ctl), 32'(C_IDLE));
    chk("mw_stall", stall_cycles, cnt(4));

    // Branch seen during a two-cycle wait is acted on at release
    nextCycle();
    EX_MEM_MemRead = 1'b1;
    branch_taken = 1'b1;
    #1;
    chk("wb_c1_ctl", 32'(ctl), 32'(C_FREEZE));
    nextCycle();
    #1;
    chk("wb_c2_ctl", 32'(ctl), 32'(C_FREEZE));
    nextCycle();
    dmem_ready = 1'b1;
    #1;
    chk("wb_rel_ctl", 32'(ctl), 32'(C_BR));
    nextCycle();
    clearIn();
    #1;
    chk("wb_after_ctl", 32'(ctl), 32'(C_IDLE));
    chk("wb_flush", flush_events, cnt(1));
    chk("wb_stall", stall_cycles, cnt(6));

    // Taken branch outranks load-use
    setLoadUse();
    branch_taken = 1'b1;
    #1;
    chk("br_pri_ctl", 32'(ctl), 32'(C_BR));
    nextCycle();
    clearIn();
    #1;
    chk("br_pri_flush", flush_events, cnt(2));
    chk("br_pri_stall", stall_cycles, cnt(6));

    // Store completing on its first MEM cycle: no stall, FSM stays in RUN
    EX_MEM_MemWrite = 1'b1;
    dmem_ready = 1'b1;
    #1;
    chk("fast_ctl", 32'(ctl), 32'(C_IDLE));
    nextCycle();
    clearIn();
    #1;
    chk("fast_after_ctl", 32'(ctl), 32'(C_IDLE));

    // Timeout after four frozen cycles
    nextCycle();
    EX_MEM_MemRead = 1'b1;
    #1;
    chk("to_c1_ctl", 32'(ctl), 32'(C_FREEZE));
    for (int i = 2; i <= 4; i++) begin
      nextCycle();
      #1;
      chk("to_wait_ctl", 32'(ctl), 32'(C_FREEZE));
      chk("to_wait_flag", 32'(mem_timeout), 32'd0);
    end
    nextCycle();
    #1;
    chk("to_rel_ctl", 32'(ctl), 32'(C_TOREL));
    chk("to_rel_flag", 32'(mem_timeout), 32'd0);
    nextCycle();
    clearIn();
    #1;
    chk("to_flag", 32'(mem_timeout), 32'd1);
    chk("to_run_ctl", 32'(ctl), 32'(C_IDLE));
    chk("to_stall", stall_cycles, cnt(10));

    // Flag persists through later traffic
    setLoadUse();
    #1;
    chk("to_lu_ctl", 32'(ctl), 32'(C_LU));
    nextCycle();
    clearIn();
    EX_MEM_MemRead = 1'b1;
    dmem_ready = 1'b1;
    #1;
    chk("to_sticky_flag", 32'(mem_timeout), 32'd1);
    chk("to_sticky_stall", stall_cycles, cnt(11));

    // Reset asserted mid MEM_WAIT
    nextCycle();
    dmem_ready = 1'b0;
    #1;
    chk("rw_c1_ctl", 32'(ctl), 32'(C_FREEZE));
    nextCycle();
    #1;
    chk("rw_c2_ctl", 32'(ctl), 32'(C_FREEZE));
    rst_n = 1'b0;
    #1;
    chk("rw_rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rw_rst_flag", 32'(mem_timeout), 32'd0);
    chk("rw_rst_stall", stall_cycles, 32'd0);
    chk("rw_rst_flush", flush_events, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    clearIn();
    #1;
    chk("rw_run_ctl", 32'(ctl), 32'(C_IDLE));
    nextCycle();
    #1;
    chk("rw_run2_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rw_stall", stall_cycles, 32'd0);
    chk("rw_flag", 32'(mem_timeout), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
